// File: rtl/audio_pdm_modulator.sv
// rtl/audio_pdm_modulator.sv - 2-entry sample FIFO, sample-rate divider and 1st-order PDM modulator
//
// Purpose:
//    Last stage of the audio sample fetch path. Samples arrive over a valid/ready
//    handshake into a 2-entry FIFO. Once every OSR clocks the head of the FIFO becomes
//    the playing sample. The playing sample is turned into a 1-bit first-order
//    sigma-delta stream. The sample-rate tick is also exported to pace the upstream fetch.
//
// Ports:
//    clk           in   system clock, rising edge
//    rst           in   synchronous reset, active-high
//    en            in   playback enable
//    s_valid       in   upstream sample valid
//    s_data        in   upstream sample, unsigned offset-binary
//    s_ready       out  FIFO not full (from registered state only)
//    pdm_out       out  registered 1-bit PDM audio
//    sample_tick   out  one-clock pulse per sample period
//    underrun      out  one-clock pulse, aligned with sample_tick, when the FIFO was empty
//    underrun_cnt  out  saturating underrun count since reset
//    cur_sample    out  sample currently being modulated

module audio_pdm_modulator #(
   parameter int SAMPLE_W   = 8,
   parameter int OSR        = 50,
   parameter int UNDERRUN_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  s_valid,
   input  logic [SAMPLE_W-1:0]   s_data,
   output logic                  s_ready,
   output logic                  pdm_out,
   output logic                  sample_tick,
   output logic                  underrun,
   output logic [UNDERRUN_W-1:0] underrun_cnt,
   output logic [SAMPLE_W-1:0]   cur_sample
);

   localparam int                DIV_W    = (OSR > 1) ? $clog2(OSR) : 1;
   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(OSR - 1);
   localparam logic [SAMPLE_W-1:0] MIDSCALE = {1'b1, {(SAMPLE_W-1){1'b0}}};

   // FIFO as a 2-deep shift structure: head_q is always the oldest entry.
   logic [SAMPLE_W-1:0]   head_q, head_d;
   logic [SAMPLE_W-1:0]   tail_q, tail_d;
   logic [1:0]            count_q, count_d;
   logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
   logic [SAMPLE_W-1:0]   acc_q, acc_d;
   logic [SAMPLE_W-1:0]   cur_sample_q, cur_sample_d;
   logic                  pdm_out_q, pdm_out_d;
   logic                  sample_tick_q, sample_tick_d;
   logic                  underrun_q, underrun_d;
   logic [UNDERRUN_W-1:0] underrun_cnt_q, underrun_cnt_d;

   logic                  push;
   logic                  pop;
   logic                  tick;
   logic [SAMPLE_W:0]     sum;

   assign s_ready      = (count_q != 2'd2);
   assign pdm_out      = pdm_out_q;
   assign sample_tick  = sample_tick_q;
   assign underrun     = underrun_q;
   assign underrun_cnt = underrun_cnt_q;
   assign cur_sample   = cur_sample_q;

   always_comb begin
      head_d         = head_q;
      tail_d         = tail_q;
      count_d        = count_q;
      div_cnt_d      = div_cnt_q;
      acc_d          = acc_q;
      cur_sample_d   = cur_sample_q;
      pdm_out_d      = 1'b0;
      underrun_cnt_d = underrun_cnt_q;

      push = s_valid && (count_q != 2'd2);
      tick = en && (div_cnt_q == DIV_LAST);
      // Pop decision uses the pre-push count, so a sample arriving on a tick into an
      // empty FIFO is not bypassed to the player.
      pop  = tick && (count_q != 2'd0);

      if (en) begin
         div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
      end else begin
         div_cnt_d = '0;
      end

      if (pop) begin
         cur_sample_d = head_q;
         head_d       = tail_q;
         count_d      = count_q - 2'd1;
      end

      // Write lands in the first free slot after any pop this cycle.
      if (push) begin
         if (count_d == 2'd0) begin
            head_d = s_data;
         end else begin
            tail_d = s_data;
         end
         count_d = count_d + 2'd1;
      end

      sample_tick_d = tick;
      underrun_d    = tick && (count_q == 2'd0);
      if (underrun_d && (underrun_cnt_q != {UNDERRUN_W{1'b1}})) begin
         underrun_cnt_d = underrun_cnt_q + 1'b1;
      end

      // Carry out of the accumulator is the PDM bit.
      sum = {1'b0, acc_q} + {1'b0, cur_sample_q};
      if (en) begin
         acc_d     = sum[SAMPLE_W-1:0];
         pdm_out_d = sum[SAMPLE_W];
      end else begin
         acc_d     = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q         <= '0;
         tail_q         <= '0;
         count_q        <= 2'd0;
         div_cnt_q      <= '0;
         acc_q          <= '0;
         cur_sample_q   <= MIDSCALE;
         pdm_out_q      <= 1'b0;
         sample_tick_q  <= 1'b0;
         underrun_q     <= 1'b0;
         underrun_cnt_q <= '0;
      end else begin
         head_q         <= head_d;
         tail_q         <= tail_d;
         count_q        <= count_d;
         div_cnt_q      <= div_cnt_d;
         acc_q          <= acc_d;
         cur_sample_q   <= cur_sample_d;
         pdm_out_q      <= pdm_out_d;
         sample_tick_q  <= sample_tick_d;
         underrun_q     <= underrun_d;
         underrun_cnt_q <= underrun_cnt_d;
      end
   end

endmodule

// File: tb/tb_audio_pdm_modulator.sv
// tb/tb_audio_pdm_modulator.sv - self-checking bench for audio_pdm_modulator

module tb_audio_pdm_modulator;

   localparam int OSR = 50;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       s_valid;
   logic [7:0] s_data;
   logic       s_ready;
   logic       pdm_out;
   logic       sample_tick;
   logic       underrun;
   logic [7:0] underrun_cnt;
   logic [7:0] cur_sample;

   int         vectors    = 0;
   int         miscompares = 0;
   logic [7:0] sb[$];
   logic [7:0] sb_exp;

   audio_pdm_modulator #(.SAMPLE_W(8), .OSR(OSR), .UNDERRUN_W(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .s_valid      (s_valid),
      .s_data       (s_data),
      .s_ready      (s_ready),
      .pdm_out      (pdm_out),
      .sample_tick  (sample_tick),
      .underrun     (underrun),
      .underrun_cnt (underrun_cnt),
      .cur_sample   (cur_sample)
   );

   always #5 clk = ~clk;

   // One clock: log the accepted sample, then advance to 2 time units past the edge.
   task automatic clk1();
      if (rst) sb.delete();
      else if (s_valid && s_ready) sb.push_back(s_data);
      @(posedge clk);
      #2;
   endtask

   // Scoreboard: every non-underrun tick must load the oldest accepted sample.
   always @(posedge clk) begin
      #1;
      if (underrun) begin
         vectors++;
         if (sample_tick !== 1'b1) begin
            miscompares++;
            $display("FAIL underrun_align: sample_tick=%b required 1", sample_tick);
         end
      end
      if (sample_tick && !underrun) begin
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL sb_empty: tick loaded %h with no sample expected", cur_sample);
         end else begin
            sb_exp = sb.pop_front();
            if (cur_sample !== sb_exp) begin
               miscompares++;
               $display("FAIL sb_order: cur_sample=%h required %h", cur_sample, sb_exp);
            end
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1; en = 1'b0; s_valid = 1'b0; s_data = 8'h00;
      clk1();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; s_valid = 1'b1; s_data = 8'h5A;
      repeat (3) clk1();
      vectors++;
      if (pdm_out !== 1'b0) begin miscompares++; $display("FAIL rst_pdm: %b required 0", pdm_out); end
      vectors++;
      if (s_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready: %b required 1", s_ready); end
      vectors++;
      if (cur_sample !== 8'h80) begin miscompares++; $display("FAIL rst_cur: %h required 80", cur_sample); end
      vectors++;
      if (underrun_cnt !== 8'h00) begin miscompares++; $display("FAIL rst_ucnt: %h required 00", underrun_cnt); end
      vectors++;
      if (sample_tick !== 1'b0 || underrun !== 1'b0) begin
         miscompares++; $display("FAIL rst_pulses: tick=%b underrun=%b required 0 0", sample_tick, underrun);
      end
      rst = 1'b0; en = 1'b0; s_valid = 1'b0;
   endtask

   // Steady feed of one value: ones in a 256-clock window must land in [lo,hi].
   task automatic test_density(input logic [7:0] val, input int lo, input int hi, input int run_clks);
      int guard;
      int ones;
      do_reset();
      s_valid = 1'b1; s_data = val; en = 1'b1;
      guard = 0;
      while (!(sample_tick && cur_sample == val) && guard < 3 * OSR) begin
         clk1();
         guard++;
      end
      vectors++;
      if (guard >= 3 * OSR) begin
         miscompares++; $display("FAIL dens_load_%h: cur_sample=%h never loaded", val, cur_sample);
      end
      clk1();
      ones = 0;
      for (int i = 0; i < run_clks; i++) begin
         clk1();
         if (i < 256 && pdm_out) ones++;
      end
      vectors++;
      if (ones < lo || ones > hi) begin
         miscompares++; $display("FAIL dens_ones_%h: %0d ones required %0d..%0d", val, ones, lo, hi);
      end
      vectors++;
      if (underrun_cnt !== 8'h00) begin
         miscompares++; $display("FAIL dens_underrun_%h: %0d required 0", val, underrun_cnt);
      end
      s_valid = 1'b0;
   endtask

   task automatic test_backpressure();
      int tk[$];
      do_reset();
      s_valid = 1'b1; s_data = 8'h10; clk1();
      s_data = 8'h20; clk1();
      s_data = 8'h30;
      repeat (3) clk1();
      vectors++;
      if (s_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready: %b required 0", s_ready); end
      vectors++;
      if (cur_sample !== 8'h80) begin miscompares++; $display("FAIL bp_hold: %h required 80", cur_sample); end
      en = 1'b1;
      for (int n = 1; n < 200; n++) begin
         logic accepted;
         accepted = s_valid && s_ready;
         clk1();
         if (accepted) s_valid = 1'b0;
         if (sample_tick) tk.push_back(n);
      end
      vectors++;
      if (tk.size() != 3) begin
         miscompares++; $display("FAIL bp_ticks: %0d ticks required 3", tk.size());
      end else begin
         vectors++;
         if (tk[0] != OSR || tk[1] != 2 * OSR || tk[2] != 3 * OSR) begin
            miscompares++; $display("FAIL bp_spacing: %0d %0d %0d required 50 100 150", tk[0], tk[1], tk[2]);
         end
      end
      vectors++;
      if (cur_sample !== 8'h30) begin miscompares++; $display("FAIL bp_third: %h required 30", cur_sample); end
      en = 1'b0;
   endtask

   task automatic test_starvation();
      int pulses;
      do_reset();
      s_valid = 1'b1; s_data = 8'hA5; clk1();
      s_valid = 1'b0; en = 1'b1;
      pulses = 0;
      for (int n = 0; n < 4 * OSR; n++) begin
         clk1();
         if (underrun) pulses++;
      end
      vectors++;
      if (pulses != 3) begin miscompares++; $display("FAIL starve_pulses: %0d required 3", pulses); end
      vectors++;
      if (cur_sample !== 8'hA5) begin miscompares++; $display("FAIL starve_hold: %h required a5", cur_sample); end
      vectors++;
      if (underrun_cnt !== 8'd3) begin miscompares++; $display("FAIL starve_cnt: %0d required 3", underrun_cnt); end
      repeat (300 * OSR) clk1();
      vectors++;
      if (underrun_cnt !== 8'hFF) begin miscompares++; $display("FAIL starve_sat: %0d required 255", underrun_cnt); end
      en = 1'b0;
   endtask

   task automatic test_push_pop();
      do_reset();
      s_valid = 1'b1; s_data = 8'h11; clk1();
      s_valid = 1'b0; en = 1'b1;
      for (int n = 1; n <= 4 * OSR; n++) begin
         s_valid = (n == OSR) || (n == 3 * OSR);
         s_data  = (n == OSR) ? 8'h22 : 8'h33;
         clk1();
         s_valid = 1'b0;
         if (n == OSR) begin
            vectors++;
            if (cur_sample !== 8'h11 || underrun !== 1'b0 || s_ready !== 1'b1) begin
               miscompares++;
               $display("FAIL pp_swap: cur=%h underrun=%b ready=%b required 11 0 1", cur_sample, underrun, s_ready);
            end
         end
         if (n == 2 * OSR) begin
            vectors++;
            if (cur_sample !== 8'h22 || underrun !== 1'b0) begin
               miscompares++; $display("FAIL pp_second: cur=%h underrun=%b required 22 0", cur_sample, underrun);
            end
         end
         if (n == 3 * OSR) begin
            vectors++;
            if (cur_sample !== 8'h22 || underrun !== 1'b1 || underrun_cnt !== 8'd1) begin
               miscompares++;
               $display("FAIL pp_nobypass: cur=%h underrun=%b cnt=%0d required 22 1 1", cur_sample, underrun, underrun_cnt);
            end
         end
         if (n == 4 * OSR) begin
            vectors++;
            if (cur_sample !== 8'h33 || underrun !== 1'b0) begin
               miscompares++; $display("FAIL pp_late: cur=%h underrun=%b required 33 0", cur_sample, underrun);
            end
         end
      end
      en = 1'b0;
   endtask

   task automatic test_midrun();
      int first;
      do_reset();
      s_valid = 1'b1; s_data = 8'hFF; en = 1'b1;
      repeat (2) clk1();
      s_valid = 1'b0;
      repeat (4 * OSR - 2) clk1();
      vectors++;
      if (underrun_cnt !== 8'd2) begin miscompares++; $display("FAIL mid_pre_cnt: %0d required 2", underrun_cnt); end
      rst = 1'b1; clk1(); rst = 1'b0;
      vectors++;
      if (cur_sample !== 8'h80 || underrun_cnt !== 8'h00 || pdm_out !== 1'b0 || s_ready !== 1'b1 || sample_tick !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_rst: cur=%h cnt=%0d pdm=%b ready=%b tick=%b required 80 0 0 1 0",
                  cur_sample, underrun_cnt, pdm_out, s_ready, sample_tick);
      end
      en = 1'b0; s_valid = 1'b1; s_data = 8'hFF; clk1();
      s_valid = 1'b0; en = 1'b1;
      repeat (OSR + 10) clk1();
      en = 1'b0; s_valid = 1'b1; s_data = 8'h44;
      clk1();
      s_valid = 1'b0;
      vectors++;
      if (pdm_out !== 1'b0 || cur_sample !== 8'hFF) begin
         miscompares++; $display("FAIL mid_endrop: pdm=%b cur=%h required 0 ff", pdm_out, cur_sample);
      end
      repeat (OSR + 5) clk1();
      vectors++;
      if (pdm_out !== 1'b0 || sample_tick !== 1'b0 || cur_sample !== 8'hFF) begin
         miscompares++; $display("FAIL mid_idle: pdm=%b tick=%b cur=%h required 0 0 ff", pdm_out, sample_tick, cur_sample);
      end
      en = 1'b1;
      first = 0;
      for (int n = 1; n <= 2 * OSR && first == 0; n++) begin
         clk1();
         if (sample_tick) first = n;
      end
      vectors++;
      if (first != OSR) begin miscompares++; $display("FAIL mid_reen_tick: %0d required %0d", first, OSR); end
      vectors++;
      if (cur_sample !== 8'h44) begin miscompares++; $display("FAIL mid_retained: %h required 44", cur_sample); end
      en = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; s_valid = 1'b0; s_data = 8'h00;
      test_reset();
      test_density(8'hC0, 191, 193, 256 * OSR);
      test_density(8'h00, 0, 0, 300);
      test_density(8'hFF, 255, 255, 300);
      test_backpressure();
      test_starvation();
      test_push_pop();
      test_midrun();
      repeat (2) clk1();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
